uart_rx: RTL and testbench

- Serial receiver directly downstream of the UART transmitter; consumes the tx line (one bit per clock) and reconstructs frames.
- Frame format is identical to the transmitter's:
  - start bit (0)
  - `length` data bits, LSB first
  - optional parity bit
  - one stop bit (1)
- Delivers each received word through a valid/ready holding register, with parity, framing and overrun status.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, receiver states and the parity rule
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int MAX_DATA_W = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Lengths of 0 or above the maximum fall back to a full-width word.
    function automatic logic [3:0] eff_len(input logic [3:0] length);
        return (length == 4'd0 || length > 4'd8) ? 4'd8 : length;
    endfunction

    // Parity is only defined for 5..8 bit words; other lengths send a fixed 0.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic [3:0]            length,
                                        input logic                  parity_type);
        logic acc;
        acc = 1'b0;
        if (length < 4'd5 || length > 4'd8) return 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < int'(length)) acc ^= data[i];
        end
        return parity_type ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: one line bit per clock, frame decode FSM and a valid/ready
// holding register carrying parity, framing and overrun status.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a start bit
//  DATA   | shifting in Leff data bits, LSB first
//  PARITY | sampling the parity bit and comparing against the expected value
//  STOP   | sampling the stop bit; the frame completes on this edge
//  BREAK  | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              rx_clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [3:0]        length,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_done,
    output logic              rx_err,
    output logic              frame_err,
    output logic              rx_overrun
);

    rx_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        len_q, len_d;
    logic              pen_q, pen_d;
    logic              ptype_q, ptype_d;
    logic              par_err_q, par_err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              complete;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        len_d     = len_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;
        ovr_d     = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx == START_LEVEL) begin
                    state_d   = DATA;
                    cnt_d     = 4'd0;
                    shift_d   = '0;
                    par_err_d = 1'b0;
                    len_d     = length;
                    pen_d     = parity_en;
                    ptype_d   = parity_type;
                end
            end
            DATA: begin
                shift_d = shift_q | (DATA_W'(rx) << cnt_q);
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == eff_len(len_q)) begin
                    state_d = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_err_d = (rx != parity_bit(MAX_DATA_W'(shift_q), len_q, ptype_q));
                state_d   = STOP;
            end
            STOP: begin
                complete = 1'b1;
                state_d  = (rx == STOP_LEVEL) ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx == IDLE_LEVEL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completing frame takes priority over a plain consume at the same edge.
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (complete) begin
            done_d = 1'b1;
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                err_d   = par_err_q;
                ferr_d  = (rx != STOP_LEVEL);
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_done    = done_q;
    assign rx_err     = err_q;
    assign frame_err  = ferr_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: frame-level reference model of the holding register,
// directed scenarios followed by randomized frames.
module tb_uart_rx;

    logic       rx_clk      = 1'b0;
    logic       rst         = 1'b0;
    logic       rx          = 1'b1;
    logic [3:0] length      = 4'd8;
    logic       parity_en   = 1'b0;
    logic       parity_type = 1'b0;
    logic       rx_ready    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_done, rx_err, frame_err, rx_overrun;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   ready_mode = 1;   // 0 low, 1 high, 2 random, 3 high only on the stop bit
    logic next_rst   = 1'b0;

    logic       exp_valid = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;
    logic       exp_err = 1'b0, exp_ferr = 1'b0, exp_known = 1'b1;
    logic [7:0] exp_data = 8'h00;

    uart_rx #(.DATA_W(8)) dut (
        .rx_clk     (rx_clk),
        .rst        (rst),
        .rx         (rx),
        .length     (length),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .frame_err  (frame_err),
        .rx_overrun (rx_overrun)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // One line bit: check what the previous edge produced, drive the next bit,
    // then advance the model to what the coming edge must produce.
    task automatic step(input logic b, input logic done_now, input logic [7:0] d,
                        input logic perr, input logic ferr);
        @(negedge rx_clk);
        check("valid", 32'(rx_valid), 32'(exp_valid));
        check("done", 32'(rx_done), 32'(exp_done));
        check("overrun", 32'(rx_overrun), 32'(exp_ovr));
        if (exp_known) begin
            check("data", 32'(rx_data), 32'(exp_data));
            check("rx_err", 32'(rx_err), 32'(exp_err));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
        end
        rx  = b;
        rst = next_rst;
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            2:       rx_ready = 1'($urandom_range(0, 1));
            default: rx_ready = done_now;
        endcase
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        if (!next_rst) begin
            exp_valid = 1'b0; exp_data = 8'h00; exp_err = 1'b0;
            exp_ferr  = 1'b0; exp_known = 1'b1;
        end else if (done_now) begin
            exp_done = 1'b1;
            if (!exp_valid || rx_ready) begin
                exp_valid = 1'b1; exp_data = d; exp_err = perr;
                exp_ferr  = ferr; exp_known = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_valid && rx_ready) begin
            exp_valid = 1'b0;
            exp_known = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [3:0] len, input logic pen,
                              input logic ptype, input logic bad_par, input logic stop_b,
                              input int brk_cycles);
        int         leff;
        logic [7:0] mask, d;
        logic       pexp;
        leff = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
        mask = 8'((1 << leff) - 1);
        d    = data & mask;
        pexp = (len >= 4'd5 && len <= 4'd8) ? (ptype ? ^d : ~^d) : 1'b0;
        length = len; parity_en = pen; parity_type = ptype;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < leff; i++) begin
            step(d[i], 1'b0, 8'h00, 1'b0, 1'b0);
            if (i == 0) begin
                // Scramble configuration mid-frame; the frame must ignore it.
                length      = 4'($urandom);
                parity_en   = 1'($urandom);
                parity_type = 1'($urandom);
            end
        end
        if (pen) step(pexp ^ bad_par, 1'b0, 8'h00, 1'b0, 1'b0);
        step(stop_b, 1'b1, d, pen & bad_par, ~stop_b);
        if (!stop_b) begin
            repeat (brk_cycles) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        next_rst = 1'b0;
        idle(2);
        next_rst = 1'b1;
        idle(2);

        // Nominal 8-bit frame with parity
        ready_mode = 1;
        send_frame(8'hA5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        idle(1);
        check("a5_data", 32'(rx_data), 32'h0A5);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_done", 32'(rx_done), 32'd1);
        check("a5_err", 32'(rx_err), 32'd0);

        // Parity error on a 5-bit word
        send_frame(8'h13, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        idle(1);
        check("par_data", 32'(rx_data), 32'h013);
        check("par_err", 32'(rx_err), 32'd1);
        check("par_ferr", 32'(frame_err), 32'd0);

        // Framing error followed by a held-low break, then a clean frame
        ready_mode = 0;
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        check("brk_data", 32'(rx_data), 32'h03C);
        check("brk_ferr", 32'(frame_err), 32'd1);
        ready_mode = 1;
        idle(1);
        send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(1);
        check("post_brk_data", 32'(rx_data), 32'h081);
        check("post_brk_ferr", 32'(frame_err), 32'd0);

        // Overrun on back-to-back frames with the consumer stalled
        ready_mode = 0;
        send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(1);
        check("ovr_pulse", 32'(rx_overrun), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h011);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        ready_mode = 1;
        idle(2);
        check("ovr_drain", 32'(rx_valid), 32'd0);

        // Accept and complete on the same edge
        ready_mode = 0;
        send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        ready_mode = 3;
        send_frame(8'h77, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(1);
        check("sim_valid", 32'(rx_valid), 32'd1);
        check("sim_data", 32'(rx_data), 32'h077);
        check("sim_ovr", 32'(rx_overrun), 32'd0);

        // Reset three bits into a frame while a word is pending
        ready_mode = 0;
        length = 4'd8; parity_en = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        next_rst = 1'b0;
        idle(2);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h000);
        next_rst = 1'b1;
        ready_mode = 1;
        idle(1);
        send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(1);
        check("rst_next_data", 32'(rx_data), 32'h05A);

        // Randomized frames against the model
        ready_mode = 2;
        for (int f = 0; f < 150; f++) begin
            send_frame(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                       $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
